// File: rtl/keypad_scanner_param.sv
// Matrix keypad scanner: one-cold column drive, two-snapshot debounce, press/release strobes,
// multi-key rejection and optional auto-repeat of the press strobe while a key is held.
module keypad_scanner_param #(
  parameter int N_ROWS          = 4,
  parameter int N_COLS          = 4,
  parameter int SETTLE_CYCLES   = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  localparam int NK = N_ROWS * N_COLS,
  localparam int KW = (NK > 1) ? $clog2(NK) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] rows,
  output logic [N_COLS-1:0] columns,
  output logic [KW-1:0]     key_code,
  output logic              key_valid,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              multi_key
);

  localparam int CW   = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int TMAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] COL_LAST    = CW'(N_COLS - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] DEB_LAST    = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RDLY_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RRATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {SCAN_A, ST_WAIT, SCAN_B, EVAL} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [NK-1:0]     snap_a_q, snap_a_d, snap_b_q, snap_b_d;
  logic [N_COLS-1:0] columns_q, columns_d;
  logic [KW-1:0]     key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              multi_q, multi_d;
  logic [RW-1:0]     rep_cnt_q, rep_cnt_d;
  logic              rep_ph_q, rep_ph_d;

  function automatic logic [N_COLS-1:0] drive(input logic [CW-1:0] c);
    drive    = '1;
    drive[c] = 1'b0;
  endfunction

  function automatic logic is_one_hot(input logic [NK-1:0] v);
    return (v != '0) && ((v & (v - NK'(1))) == '0);
  endfunction

  function automatic logic [KW-1:0] bit_index(input logic [NK-1:0] v);
    bit_index = '0;
    for (int i = NK - 1; i >= 0; i--)
      if (v[i]) bit_index = KW'(i);
  endfunction

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    snap_a_d    = snap_a_q;
    snap_b_d    = snap_b_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    multi_d     = multi_q;
    rep_cnt_d   = rep_cnt_q;
    rep_ph_d    = rep_ph_q;

    case (state_q)
      SCAN_A, SCAN_B: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (state_q == SCAN_A) snap_a_d[int'(col_q) * N_ROWS +: N_ROWS] = ~rows;
          else                   snap_b_d[int'(col_q) * N_ROWS +: N_ROWS] = ~rows;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = (state_q == SCAN_A) ? ST_WAIT : EVAL;
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = SCAN_B;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = SCAN_A;
        if (snap_a_q == snap_b_q && snap_a_q == '0) begin
          multi_d = 1'b0;
          if (key_valid_q) begin
            key_valid_d = 1'b0;
            release_d   = 1'b1;
          end
        end else if (!key_valid_q && snap_a_q == snap_b_q) begin
          if (is_one_hot(snap_a_q)) begin
            key_code_d  = bit_index(snap_a_q);
            key_valid_d = 1'b1;
            press_d     = 1'b1;
          end else begin
            multi_d = 1'b1;
          end
        end
      end
    endcase

    // Repeat timer runs off key_valid alone; a release in the same cycle wins over a repeat.
    if (REPEAT_EN == 0 || !key_valid_q || release_d) begin
      rep_cnt_d = '0;
      rep_ph_d  = 1'b0;
    end else if (rep_cnt_q == (rep_ph_q ? RRATE_LAST : RDLY_LAST)) begin
      rep_cnt_d = '0;
      rep_ph_d  = 1'b1;
      press_d   = 1'b1;
    end else begin
      rep_cnt_d = rep_cnt_q + RW'(1);
    end

    columns_d = (state_d == SCAN_A || state_d == SCAN_B) ? drive(col_d) : '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN_A;
      col_q       <= '0;
      cnt_q       <= '0;
      snap_a_q    <= '0;
      snap_b_q    <= '0;
      columns_q   <= '1;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      multi_q     <= 1'b0;
      rep_cnt_q   <= '0;
      rep_ph_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      snap_a_q    <= snap_a_d;
      snap_b_q    <= snap_b_d;
      columns_q   <= columns_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      press_q     <= press_d;
      release_q   <= release_d;
      multi_q     <= multi_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_ph_q    <= rep_ph_d;
    end
  end

  assign columns       = columns_q;
  assign key_code      = key_code_q;
  assign key_valid     = key_valid_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign multi_key     = multi_q;

endmodule
